// File: rtl/sw_onehot_reader.sv
// ============================================================================
//  Module   : sw_onehot_reader
//  Brief    : Synchronises and debounces a 10-bit one-hot slide-switch bank
//             and decodes the accepted pattern into a registered binary index.
//  Options  : define PRIORITY_ENCODE_EN to resolve multi-hot patterns to the
//             lowest set bit instead of flagging sel_err.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_onehot_reader #(
  parameter int PRESCALE_W = 14,
  parameter int DEB_COUNT  = 4
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic [9:0] sw,
  output logic [3:0] sel,
  output logic       sel_valid,
  output logic       sel_err,
  output logic       sel_changed
);

  localparam logic [3:0]            c_deb     = 4'(DEB_COUNT);
  localparam logic [PRESCALE_W-1:0] c_pre_one = PRESCALE_W'(1);

  logic [9:0]            r_sw_meta;
  logic [9:0]            r_sw_s;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [9:0]            r_cand;
  logic [3:0]            r_match;
  logic [9:0]            r_acc;
  logic [3:0]            r_sel;
  logic                  r_sel_valid;
  logic                  r_sel_err;
  logic                  r_sel_changed;

  logic                  w_tick;
  logic [3:0]            w_match_inc;
  logic                  w_onehot;
  logic [3:0]            w_low;
  logic [3:0]            w_sel;
  logic                  w_valid;
  logic                  w_err;
  logic                  w_changed;

  assign w_tick      = &r_prescale;
  assign w_match_inc = (r_match == c_deb) ? c_deb : (r_match + 4'd1);
  assign w_onehot    = (r_acc != 10'd0) && ((r_acc & (r_acc - 10'd1)) == 10'd0);

  // Lowest set bit of the accepted pattern; scanning downward lets bit 0 win.
  always_comb begin
    w_low = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (r_acc[i]) w_low = 4'(i);
    end
  end

  always_comb begin
    w_sel   = r_sel;
    w_valid = 1'b0;
    w_err   = 1'b0;
    if (r_acc == 10'd0) begin
      w_valid = 1'b0;
    end else if (w_onehot) begin
      w_sel   = w_low;
      w_valid = 1'b1;
    end else begin
`ifdef PRIORITY_ENCODE_EN
      w_sel   = w_low;
      w_valid = 1'b1;
`else
      w_err   = 1'b1;
`endif
    end
    w_changed = w_valid && (!r_sel_valid || (w_sel != r_sel));
  end

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_sw_meta     <= 10'd0;
      r_sw_s        <= 10'd0;
      r_prescale    <= '0;
      r_cand        <= 10'd0;
      r_match       <= 4'd0;
      r_acc         <= 10'd0;
      r_sel         <= 4'd0;
      r_sel_valid   <= 1'b0;
      r_sel_err     <= 1'b0;
      r_sel_changed <= 1'b0;
    end else begin
      r_sw_meta  <= sw;
      r_sw_s     <= r_sw_meta;
      r_prescale <= r_prescale + c_pre_one;
      if (w_tick) begin
        if (r_sw_s != r_cand) begin
          r_cand  <= r_sw_s;
          r_match <= 4'd1;
        end else begin
          r_match <= w_match_inc;
          // Reloading an identical pattern once saturated is harmless.
          if (w_match_inc == c_deb) r_acc <= r_cand;
        end
      end
      r_sel         <= w_sel;
      r_sel_valid   <= w_valid;
      r_sel_err     <= w_err;
      r_sel_changed <= w_changed;
    end
  end

  assign sel         = r_sel;
  assign sel_valid   = r_sel_valid;
  assign sel_err     = r_sel_err;
  assign sel_changed = r_sel_changed;

endmodule

`default_nettype wire

// File: tb/tb_sw_onehot_reader.sv
// ============================================================================
//  Module   : tb_sw_onehot_reader
//  Brief    : Self-checking bench for sw_onehot_reader (PRESCALE_W=4,
//             DEB_COUNT=4) against a tick-sample history reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sw_onehot_reader;

  localparam int PW   = 4;
  localparam int DEB  = 4;
  localparam int TICK = 1 << PW;
`ifdef PRIORITY_ENCODE_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic       clk_50M = 1'b0;
  logic       reset   = 1'b1;
  logic [9:0] sw      = 10'd0;
  logic [3:0] sel;
  logic       sel_valid;
  logic       sel_err;
  logic       sel_changed;

  int n_vec = 0;
  int n_err = 0;

  sw_onehot_reader #(.PRESCALE_W(PW), .DEB_COUNT(DEB)) dut (
    .clk_50M    (clk_50M),
    .reset      (reset),
    .sw         (sw),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .sel_err    (sel_err),
    .sel_changed(sel_changed)
  );

  always #10 clk_50M = ~clk_50M;

  // Reference model: clock count since reset gives the tick, the last DEB tick
  // samples of the synchronised input decide acceptance.
  logic [9:0] m_s1, m_s2, m_acc;
  logic [9:0] m_q[$];
  int         m_cyc;
  logic [3:0] m_sel;
  logic       m_valid, m_err, m_chg;

  always @(posedge clk_50M) begin
    int  ones, low;
    bit  same;
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_acc = 0; m_q.delete(); m_cyc = 0;
      m_sel = 0; m_valid = 0; m_err = 0; m_chg = 0;
    end else begin
      ones = $countones(m_acc);
      low  = 0;
      for (int i = 9; i >= 0; i--) if (m_acc[i]) low = i;
      m_chg = 0;
      if (ones == 1 || (PRIO && ones > 1)) begin
        m_chg   = !m_valid || (m_sel != 4'(low));
        m_sel   = 4'(low);
        m_valid = 1;
        m_err   = 0;
      end else if (ones == 0) begin
        m_valid = 0; m_err = 0;
      end else begin
        m_valid = 0; m_err = 1;
      end
      if ((m_cyc % TICK) == TICK - 1) begin
        m_q.push_back(m_s2);
        if (m_q.size() > DEB) void'(m_q.pop_front());
        same = (m_q.size() == DEB);
        foreach (m_q[k]) if (m_q[k] != m_q[0]) same = 0;
        if (same) m_acc = m_q[0];
      end
      m_cyc++;
      m_s2 = m_s1;
      m_s1 = sw;
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    sw    = 10'($urandom);
    repeat (3) begin
      @(negedge clk_50M);
      n_vec++;
      if ({sel, sel_valid, sel_err, sel_changed} !== 7'd0) begin
        n_err++;
        $display("FAIL reset_outputs: got %h expected 00", {sel, sel_valid, sel_err, sel_changed});
      end
    end
  endtask

  task automatic test_first_accept();
    int pulses = 0;
    sw    = 10'b00000_01000;
    reset = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk_50M);
      n_vec++;
      if ({sel, sel_valid, sel_err, sel_changed} !== {m_sel, m_valid, m_err, m_chg}) begin
        n_err++;
        $display("FAIL first_accept cyc %0d: got %h expected %h", i,
                 {sel, sel_valid, sel_err, sel_changed}, {m_sel, m_valid, m_err, m_chg});
      end
      if (sel_changed) pulses++;
      if (i == 64) begin
        n_vec++;
        if (sel_valid !== 1'b0) begin
          n_err++;
          $display("FAIL first_accept_early: sel_valid got %b expected 0", sel_valid);
        end
      end
      if (i == 65) begin
        n_vec++;
        if ({sel, sel_valid, sel_changed} !== {4'd3, 1'b1, 1'b1}) begin
          n_err++;
          $display("FAIL first_accept_latency: got sel=%0d v=%b chg=%b expected sel=3 v=1 chg=1",
                   sel, sel_valid, sel_changed);
        end
      end
    end
    n_vec++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL first_accept_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    logic [9:0] pat [3] = '{10'b00000_00001, 10'b00000_00010, 10'b00000_00001};
    int         len [3] = '{5 * TICK, 2 * TICK, 6 * TICK};
    for (int p = 0; p < 3; p++) begin
      sw = pat[p];
      repeat (len[p]) begin
        @(negedge clk_50M);
        n_vec++;
        if ({sel, sel_valid, sel_err, sel_changed} !== {m_sel, m_valid, m_err, m_chg}) begin
          n_err++;
          $display("FAIL glitch: got %h expected %h",
                   {sel, sel_valid, sel_err, sel_changed}, {m_sel, m_valid, m_err, m_chg});
        end
        if (p > 0 && sel_changed) pulses++;
      end
    end
    n_vec++;
    if (pulses != 0 || sel !== 4'd0 || sel_valid !== 1'b1) begin
      n_err++;
      $display("FAIL glitch_reject: got sel=%0d v=%b pulses=%0d expected sel=0 v=1 pulses=0",
               sel, sel_valid, pulses);
    end
  endtask

  task automatic test_multihot();
    sw = 10'b10000_00100;
    repeat (6 * TICK) begin
      @(negedge clk_50M);
      n_vec++;
      if ({sel, sel_valid, sel_err, sel_changed} !== {m_sel, m_valid, m_err, m_chg}) begin
        n_err++;
        $display("FAIL multihot: got %h expected %h",
                 {sel, sel_valid, sel_err, sel_changed}, {m_sel, m_valid, m_err, m_chg});
      end
    end
    n_vec++;
    if (PRIO ? ({sel, sel_valid, sel_err} !== {4'd2, 1'b1, 1'b0})
             : ({sel, sel_valid, sel_err} !== {4'd0, 1'b0, 1'b1})) begin
      n_err++;
      $display("FAIL multihot_final: got sel=%0d v=%b e=%b", sel, sel_valid, sel_err);
    end
  endtask

  task automatic test_zero_hold();
    int pulses = 0;
    logic [9:0] pat [3] = '{10'b10000_00000, 10'b00000_00000, 10'b10000_00000};
    for (int p = 0; p < 3; p++) begin
      sw = pat[p];
      repeat (6 * TICK) begin
        @(negedge clk_50M);
        n_vec++;
        if ({sel, sel_valid, sel_err, sel_changed} !== {m_sel, m_valid, m_err, m_chg}) begin
          n_err++;
          $display("FAIL zero_hold: got %h expected %h",
                   {sel, sel_valid, sel_err, sel_changed}, {m_sel, m_valid, m_err, m_chg});
        end
        if (p == 2 && sel_changed) pulses++;
      end
      if (p == 1) begin
        n_vec++;
        if ({sel, sel_valid, sel_err} !== {4'd9, 1'b0, 1'b0}) begin
          n_err++;
          $display("FAIL zero_hold_idle: got sel=%0d v=%b e=%b expected 9 0 0", sel, sel_valid, sel_err);
        end
      end
    end
    n_vec++;
    if (pulses != 1 || sel !== 4'd9 || sel_valid !== 1'b1) begin
      n_err++;
      $display("FAIL zero_hold_reselect: got sel=%0d pulses=%0d expected 9 1", sel, pulses);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    @(negedge clk_50M);
    sw    = 10'b00001_00000;
    reset = 1'b0;
    repeat (3 * TICK + 2) @(negedge clk_50M);
    reset = 1'b1;
    @(negedge clk_50M);
    reset = 1'b0;
    n_vec++;
    if ({sel, sel_valid, sel_err, sel_changed} !== 7'd0) begin
      n_err++;
      $display("FAIL reset_mid_clear: got %h expected 00", {sel, sel_valid, sel_err, sel_changed});
    end
    for (int i = 1; i <= 5 * TICK; i++) begin
      @(negedge clk_50M);
      n_vec++;
      if ({sel, sel_valid, sel_err, sel_changed} !== {m_sel, m_valid, m_err, m_chg}) begin
        n_err++;
        $display("FAIL reset_mid cyc %0d: got %h expected %h", i,
                 {sel, sel_valid, sel_err, sel_changed}, {m_sel, m_valid, m_err, m_chg});
      end
      if (i == 4 * TICK) begin
        n_vec++;
        if (sel_valid !== 1'b0) begin
          n_err++;
          $display("FAIL reset_mid_fresh: sel_valid got %b expected 0 before 4 new ticks", sel_valid);
        end
      end
    end
    n_vec++;
    if ({sel, sel_valid} !== {4'd5, 1'b1}) begin
      n_err++;
      $display("FAIL reset_mid_accept: got sel=%0d v=%b expected 5 1", sel, sel_valid);
    end
  endtask

  task automatic test_sweep();
    int pulses = 0;
    reset = 1'b1;
    @(negedge clk_50M);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sw = 10'(1 << k);
      repeat (5 * TICK) begin
        @(negedge clk_50M);
        n_vec++;
        if ({sel, sel_valid, sel_err, sel_changed} !== {m_sel, m_valid, m_err, m_chg}) begin
          n_err++;
          $display("FAIL sweep: got %h expected %h",
                   {sel, sel_valid, sel_err, sel_changed}, {m_sel, m_valid, m_err, m_chg});
        end
        if (sel_changed) begin
          n_vec++;
          if (sel !== 4'(pulses)) begin
            n_err++;
            $display("FAIL sweep_order: got sel=%0d expected %0d", sel, pulses);
          end
          pulses++;
        end
      end
    end
    n_vec++;
    if (pulses != 10) begin
      n_err++;
      $display("FAIL sweep_pulses: got %0d expected 10", pulses);
    end
  endtask

  task automatic test_random();
    logic [9:0] pat;
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 3))
        0: pat = 10'(1 << $urandom_range(0, 9));
        1: pat = 10'(1 << $urandom_range(0, 9)) | 10'(1 << $urandom_range(0, 9));
        2: pat = 10'd0;
        default: pat = 10'($urandom);
      endcase
      sw = pat;
      repeat ($urandom_range(1, 90)) begin
        @(negedge clk_50M);
        n_vec++;
        if ({sel, sel_valid, sel_err, sel_changed} !== {m_sel, m_valid, m_err, m_chg}) begin
          n_err++;
          $display("FAIL random seg %0d: got %h expected %h", s,
                   {sel, sel_valid, sel_err, sel_changed}, {m_sel, m_valid, m_err, m_chg});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_accept();
    test_glitch();
    test_multihot();
    test_zero_hold();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
